// File: rtl/inv_cipher_iter.sv
// inv_cipher_iter: iterative AES inverse cipher, one inverse round per clock, round keys fetched by index
module inv_shift_rows (
  input  logic [127:0] d,
  output logic [127:0] q
);
  for (genvar r = 0; r < 4; r++) begin : g_r
    for (genvar c = 0; c < 4; c++) begin : g_c
      assign q[127-8*(r+4*c) -: 8] = d[127-8*(r+4*((c+4-r)%4)) -: 8];
    end
  end
endmodule

module inv_sub_bytes (
  input  logic [127:0] d,
  output logic [127:0] q
);
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  // inverse affine, then GF(2^8) inverse as x^254 (maps 0 to 0)
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] y, s, r;
    y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    s = y;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r;
  endfunction
  for (genvar i = 0; i < 16; i++) begin : g_b
    assign q[127-8*i -: 8] = inv_sbox(d[127-8*i -: 8]);
  end
endmodule

module inv_mix_columns (
  input  logic [127:0] d,
  output logic [127:0] q
);
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 4; i++) begin
      p = k[i] ? p ^ x : p;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  for (genvar c = 0; c < 4; c++) begin : g_c
    for (genvar r = 0; r < 4; r++) begin : g_r
      assign q[127-8*(r+4*c) -: 8] = gm(d[127-8*(4*c+r) -: 8], 4'he)
                                   ^ gm(d[127-8*(4*c+(r+1)%4) -: 8], 4'hb)
                                   ^ gm(d[127-8*(4*c+(r+2)%4) -: 8], 4'hd)
                                   ^ gm(d[127-8*(4*c+(r+3)%4) -: 8], 4'h9);
    end
  end
endmodule

module inv_cipher_iter #(
  parameter int NUM_ROUNDS = 12,
  parameter int RK_IDX_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        in_data,
  output logic [RK_IDX_W-1:0] rk_idx,
  input  logic [127:0]        rk_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out_data
);
  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;
  localparam logic [RK_IDX_W-1:0] LAST = RK_IDX_W'(NUM_ROUNDS);
  state_t st, st_nx;
  logic [RK_IDX_W-1:0] cnt, cnt_nx;
  logic [127:0] sr, sr_nx, isr, isb, ark, imc;
  inv_shift_rows  u_isr (.d(sr),  .q(isr));
  inv_sub_bytes   u_isb (.d(isr), .q(isb));
  assign ark = isb ^ rk_data;
  inv_mix_columns u_imc (.d(ark), .q(imc));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st  <= IDLE;
      cnt <= LAST;
      sr  <= '0;
    end else begin
      st  <= st_nx;
      cnt <= cnt_nx;
      sr  <= sr_nx;
    end
  end
  always_comb begin
    st_nx     = st;
    cnt_nx    = cnt;
    sr_nx     = sr;
    in_ready  = st == IDLE;
    out_valid = st == DONE;
    rk_idx    = st == ROUND ? cnt : st == FINAL ? '0 : LAST;
    case (st)
      IDLE: if (in_valid) begin
        sr_nx  = in_data ^ rk_data;
        cnt_nx = LAST - 1'b1;
        st_nx  = ROUND;
      end
      ROUND: begin
        sr_nx  = imc;
        cnt_nx = cnt - 1'b1;
        st_nx  = cnt == RK_IDX_W'(1) ? FINAL : ROUND;
      end
      FINAL: begin
        sr_nx = ark;
        st_nx = DONE;
      end
      DONE: st_nx = out_ready ? IDLE : DONE;
    endcase
  end
  assign out_data = sr;
endmodule
